// File: rtl/floor_scroller.sv
// rtl/floor_scroller.sv - double-buffered scrolling floor-segment generator
module floor_scroller #(
   parameter int          NUM_FLOORS = 8,
   parameter int          POS_W      = 10,
   parameter int          SCREEN_H   = 480,
   parameter int          SPACING    = 60,
   parameter int          X_STEP     = 40,
   parameter int          X_SLOTS    = 16,
   parameter int          GAP_EN     = 0,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tick,
   input  logic                          frame_sync,
   input  logic                          run,
   input  logic [1:0]                    level,
   output logic [NUM_FLOORS*POS_W-1:0]   floor_x,
   output logic [NUM_FLOORS*POS_W-1:0]   floor_y,
   output logic [NUM_FLOORS-1:0]         enable,
   output logic [15:0]                   wrap_cnt
);

   localparam int CNT_W = $clog2(NUM_FLOORS + 1);
   localparam logic [3:0] SLOT_MASK = 4'(X_SLOTS - 1);

   // Working (live) floor state
   logic [POS_W-1:0] wx_q [NUM_FLOORS];
   logic [POS_W-1:0] wx_d [NUM_FLOORS];
   logic [POS_W-1:0] wy_q [NUM_FLOORS];
   logic [POS_W-1:0] wy_d [NUM_FLOORS];
   logic [NUM_FLOORS-1:0] wen_q, wen_d;

   // Shadow copies seen by the renderer
   logic [NUM_FLOORS*POS_W-1:0] sx_q, sy_q;
   logic [NUM_FLOORS-1:0]       sen_q;

   logic [15:0] lfsr_q, lfsr_d;
   logic [2:0]  presc_q, presc_d;
   logic        pending_q, pending_d;
   logic [15:0] wrap_q, wrap_d;

   logic [2:0]       mask;
   logic             step;
   logic             load;
   logic [CNT_W-1:0] nwrap;
   logic [16:0]      wrap_sum;
   logic [3:0]       slot;
   logic             gap;

   assign floor_x  = sx_q;
   assign floor_y  = sy_q;
   assign enable   = sen_q;
   assign wrap_cnt = wrap_q;

   // Step decision, LFSR advance, per-floor scroll/respawn and respawn counting
   always_comb begin
      mask      = 3'd0;
      nwrap     = '0;
      slot      = 4'd0;
      gap       = 1'b0;
      case (level)
         2'd0:    mask = 3'd0;
         2'd1:    mask = 3'd1;
         2'd2:    mask = 3'd3;
         default: mask = 3'd7;
      endcase
      step      = tick & run & ((presc_q & mask) == 3'd0);
      load      = frame_sync & pending_q;
      presc_d   = (tick & run) ? presc_q + 3'd1 : presc_q;
      pending_d = step | (pending_q & ~frame_sync);
      lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      wen_d     = wen_q;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         wx_d[i] = wx_q[i];
         wy_d[i] = wy_q[i];
         // Floor i sees the LFSR rotated left by 3i: bit b comes from bit (b-3i) mod 16
         for (int b = 0; b < 4; b++) begin
            slot[b] = lfsr_q[4'(b - 3 * i)];
         end
         gap = lfsr_q[4'(7 - 3 * i)] & lfsr_q[4'(5 - 3 * i)];
         if (step) begin
            if (wy_q[i] == POS_W'(SCREEN_H - 1)) begin
               wy_d[i]  = '0;
               wx_d[i]  = POS_W'(int'(slot & SLOT_MASK) * X_STEP);
               wen_d[i] = (GAP_EN != 0) ? ~gap : 1'b1;
               nwrap    = nwrap + CNT_W'(1);
            end else begin
               wy_d[i] = wy_q[i] + POS_W'(1);
            end
         end
      end
      wrap_sum = {1'b0, wrap_q} + 17'(nwrap);
      wrap_d   = wrap_sum[16] ? 16'hFFFF : wrap_sum[15:0];
   end

   // Working registers: reset to the staggered start layout, otherwise follow next-state
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_FLOORS; i++) begin
            wy_q[i] <= POS_W'(i * SPACING);
            wx_q[i] <= POS_W'(((5 * i + 3) % X_SLOTS) * X_STEP);
         end
         wen_q <= '1;
      end else begin
         for (int i = 0; i < NUM_FLOORS; i++) begin
            wy_q[i] <= wy_d[i];
            wx_q[i] <= wx_d[i];
         end
         wen_q <= wen_d;
      end
   end

   // Shadow registers: copy pre-step working values on a frame strobe with an update pending
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_FLOORS; i++) begin
            sy_q[i*POS_W +: POS_W] <= POS_W'(i * SPACING);
            sx_q[i*POS_W +: POS_W] <= POS_W'(((5 * i + 3) % X_SLOTS) * X_STEP);
         end
         sen_q <= '1;
      end else if (load) begin
         for (int i = 0; i < NUM_FLOORS; i++) begin
            sy_q[i*POS_W +: POS_W] <= wy_q[i];
            sx_q[i*POS_W +: POS_W] <= wx_q[i];
         end
         sen_q <= wen_q;
      end
   end

   // Control state: LFSR, prescaler, pending flag and respawn counter
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q    <= LFSR_SEED;
         presc_q   <= 3'd0;
         pending_q <= 1'b0;
         wrap_q    <= 16'd0;
      end else begin
         lfsr_q    <= lfsr_d;
         presc_q   <= presc_d;
         pending_q <= pending_d;
         wrap_q    <= wrap_d;
      end
   end

endmodule

// File: tb/tb_floor_scroller.sv
// tb/tb_floor_scroller.sv - scoreboard bench for floor_scroller with a reference model
module tb_floor_scroller;

   localparam int NF = 8;
   localparam int PW = 10;
   localparam int SH = 480;
   localparam int SP = 60;
   localparam int XS = 40;
   localparam int XN = 16;
   localparam int SEED = 16'hACE1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic frame_sync = 1'b0;
   logic run = 1'b0;
   logic [1:0] level = 2'd0;
   logic [NF*PW-1:0] floor_x, floor_y;
   logic [NF-1:0]    enable;
   logic [15:0]      wrap_cnt;

   always #5 clk = ~clk;

   floor_scroller #(.NUM_FLOORS(NF), .POS_W(PW), .SCREEN_H(SH), .SPACING(SP),
                    .X_STEP(XS), .X_SLOTS(XN), .GAP_EN(1), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst(rst), .tick(tick), .frame_sync(frame_sync), .run(run),
      .level(level), .floor_x(floor_x), .floor_y(floor_y), .enable(enable),
      .wrap_cnt(wrap_cnt));

   typedef struct packed {
      logic [NF*PW-1:0] x;
      logic [NF*PW-1:0] y;
      logic [NF-1:0]    en;
   } snap_t;

   snap_t exp_q[$];
   snap_t cur_s, prev_s, exp_s;
   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;

   // reference model state
   int m_x[NF], m_y[NF], m_en[NF];
   int s_x[NF], s_y[NF], s_en[NF];
   int m_lfsr, m_presc, m_pend, m_wrap, m_steps, m_respawns, m_gaps;

   function automatic snap_t shadow_snap();
      snap_t s;
      for (int i = 0; i < NF; i++) begin
         s.x[i*PW +: PW] = PW'(s_x[i]);
         s.y[i*PW +: PW] = PW'(s_y[i]);
         s.en[i]         = s_en[i][0];
      end
      return s;
   endfunction

   function automatic void model_reset(input bit may_push);
      bit changed = 1'b0;
      for (int i = 0; i < NF; i++) begin
         m_y[i] = i * SP;
         m_x[i] = ((5 * i + 3) % XN) * XS;
         m_en[i] = 1;
         if (s_y[i] != m_y[i] || s_x[i] != m_x[i] || s_en[i] != 1) changed = 1'b1;
         s_y[i] = m_y[i];
         s_x[i] = m_x[i];
         s_en[i] = 1;
      end
      m_lfsr = SEED; m_presc = 0; m_pend = 0; m_wrap = 0;
      if (may_push && changed) exp_q.push_back(shadow_snap());
   endfunction

   function automatic void model_edge(input bit r, input bit t, input bit f, input bit ru, input int lv);
      bit st;
      int rot, k;
      if (r) begin
         model_reset(1'b1);
         return;
      end
      st = t && ru && ((m_presc % (1 << lv)) == 0);
      if (f && m_pend != 0) begin
         for (int i = 0; i < NF; i++) begin
            s_x[i] = m_x[i]; s_y[i] = m_y[i]; s_en[i] = m_en[i];
         end
         exp_q.push_back(shadow_snap());
      end
      if (st) begin
         m_steps++;
         for (int i = 0; i < NF; i++) begin
            if (m_y[i] == SH - 1) begin
               k = (3 * i) % 16;
               rot = ((m_lfsr << k) | (m_lfsr >> (16 - k))) & 16'hFFFF;
               m_y[i] = 0;
               m_x[i] = (rot % XN) * XS;
               m_en[i] = (((rot >> 7) & 1) == 1 && ((rot >> 5) & 1) == 1) ? 0 : 1;
               m_respawns++;
               if (m_en[i] == 0) m_gaps++;
               m_wrap = (m_wrap < 65535) ? m_wrap + 1 : 65535;
            end else begin
               m_y[i] = m_y[i] + 1;
            end
         end
      end
      if (t && ru) m_presc = (m_presc + 1) % 8;
      m_pend = (st || (m_pend != 0 && !f)) ? 1 : 0;
      m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 16'hFFFF;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int get_y(input int i);
      return int'(floor_y[i*PW +: PW]);
   endfunction

   function automatic int get_x(input int i);
      return int'(floor_x[i*PW +: PW]);
   endfunction

   task automatic cyc(input bit r, input bit t, input bit f, input bit ru, input int lv);
      rst = r; tick = t; frame_sync = f; run = ru; level = 2'(lv);
      @(posedge clk);
      model_edge(r, t, f, ru, lv);
      @(negedge clk);
   endtask

   // monitor: pop an expected snapshot whenever the shadow outputs change; track wrap_cnt every cycle
   always @(negedge clk) begin
      if (mon_en) begin
         cur_s = {floor_x, floor_y, enable};
         if (cur_s !== prev_s) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_update actual=%h expected=no_change", cur_s);
            end else begin
               exp_s = exp_q.pop_front();
               if (cur_s !== exp_s) begin
                  failures++;
                  $display("FAIL shadow_update actual=%h expected=%h", cur_s, exp_s);
               end
            end
            prev_s = cur_s;
         end
         checks++;
         if (wrap_cnt !== 16'(m_wrap)) begin
            failures++;
            $display("FAIL wrap_cnt actual=%0d expected=%0d", wrap_cnt, m_wrap);
         end
      end
   end

   initial begin
      bit did_rst = 1'b0;
      int cycles = 0;
      int lv = 0;
      m_steps = 0; m_respawns = 0; m_gaps = 0;
      model_reset(1'b0);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      prev_s = {floor_x, floor_y, enable};
      mon_en = 1'b1;

      // reset values, frame_sync with nothing pending
      cyc(0, 0, 1, 1, 0);
      check("reset_y1", get_y(1), 60);
      check("reset_x0", get_x(0), 120);
      check("reset_en", int'(enable), 8'hFF);
      check("reset_wrap", int'(wrap_cnt), 0);
      check("reset_y7", get_y(7), 420);

      // three steps at level 0: invisible until frame_sync
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0);
      check("pre_fs_y0", get_y(0), 0);
      check("pre_fs_y7", get_y(7), 420);
      cyc(0, 0, 1, 1, 0);
      check("post_fs_y0", get_y(0), 3);
      check("post_fs_y7", get_y(7), 423);

      // level 2: eight ticks give two steps
      for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, 2);
      cyc(0, 0, 1, 1, 2);
      check("lvl2_y0", get_y(0), 5);
      check("lvl2_y7", get_y(7), 425);

      // floor 7 to 479, then one more step wraps it
      for (int i = 0; i < 54; i++) cyc(0, 1, 0, 1, 0);
      cyc(0, 0, 1, 1, 0);
      check("edge_y7", get_y(7), 479);
      cyc(0, 1, 0, 1, 0);
      cyc(0, 0, 1, 1, 0);
      check("wrap_y7", get_y(7), 0);
      check("wrap_x7_mult", get_x(7) % XS, 0);
      check("wrap_x7_range", (get_x(7) < 640) ? 1 : 0, 1);
      check("wrap_cnt_1", int'(wrap_cnt), 1);

      // step and frame_sync in the same cycle
      cyc(0, 1, 0, 1, 0);
      cyc(0, 1, 1, 1, 0);
      check("same_cycle_pre", get_y(0), 61);
      cyc(0, 0, 1, 1, 0);
      check("same_cycle_post", get_y(0), 62);

      // randomized run with a mid-run reset
      while (m_steps < 4100 && cycles < 40000) begin
         if ($urandom_range(0, 199) == 0) lv = $urandom_range(0, 3);
         if (!did_rst && m_steps >= 2000) begin
            did_rst = 1'b1;
            cyc(1, $urandom_range(0, 1), $urandom_range(0, 1), 1, lv);
            check("midrst_y1", get_y(1), 60);
            check("midrst_x0", get_x(0), 120);
            check("midrst_en", int'(enable), 8'hFF);
            check("midrst_wrap", int'(wrap_cnt), 0);
         end else begin
            cyc(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 9) != 0), lv);
         end
         cycles++;
      end
      check("step_budget", (m_steps >= 4000) ? 1 : 0, 1);
      check("midrst_done", did_rst ? 1 : 0, 1);

      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      check("queue_drained", exp_q.size(), 0);
      check("respawns_seen", (m_respawns > 20) ? 1 : 0, 1);
      if (m_respawns > 0)
         check("gap_ratio", (m_gaps * 100 / m_respawns >= 10 && m_gaps * 100 / m_respawns <= 45) ? 1 : 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/floor_scroller.md
# floor_scroller

Parametrised platform-field generator for the falling-cube game. It holds `NUM_FLOORS` floor segments that scroll down the screen at a selectable rate. A segment that leaves the bottom edge respawns at the top with a pseudo-random column and, optionally, as a gap. Positions are double-buffered: the renderer reads shadow registers that change only on a frame-sync strobe, so a scroll step never tears mid-frame. The block sits between the game-timing logic (tick and level) and the VGA pixel pipeline and collision checker.

## Interface
- `NUM_FLOORS`, 8, number of floor segments (2..16)
- `POS_W`, 10, coordinate width in bits
- `SCREEN_H`, 480, visible rows; y wraps at `SCREEN_H-1`
- `SPACING`, 60, reset vertical pitch between consecutive floors
- `X_STEP`, 40, pixel pitch of a spawn column
- `X_SLOTS`, 16, number of spawn columns (power of 2, ≤ 16)
- `GAP_EN`, 0, when 1 a respawn may produce a disabled (gap) floor
- `LFSR_SEED`, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `tick`  in  1  one-cycle scroll-step strobe
- `frame_sync`  in  1  one-cycle vertical-blank strobe from the VGA timing block
- `run`  in  1  scrolling allowed (game active, not paused)
- `level`  in  2  speed: 0 = every tick, 1 = every 2nd, 2 = every 4th, 3 = every 8th
- `floor_x`  out  `NUM_FLOORS*POS_W`  shadow x positions; floor i is at `[i*POS_W +: POS_W]`
- `floor_y`  out  `NUM_FLOORS*POS_W`  shadow y positions, same packing
- `enable`  out  `NUM_FLOORS`  shadow per-floor visible/solid flag
- `wrap_cnt`  out  16  count of respawns, saturating at 16'hFFFF (used as score)

## Operation
- Working registers `wx[i]`, `wy[i]`, `wen[i]` hold the live state. Shadow registers drive `floor_x`, `floor_y` and `enable`.
- Reset values:
  - `wy[i]` = shadow y = i*`SPACING`.
  - `wx[i]` = shadow x = ((5i+3) mod `X_SLOTS`)*`X_STEP`.
  - `wen` = `enable` = all ones.
  - `wrap_cnt` = 0, prescaler = 0, `pending` = 0, LFSR = `LFSR_SEED`.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every clock when not in reset.
- Prescaler: a 3-bit counter that increments on each `tick` while `run`=1.
  - Step condition: `tick` & `run` & (prescaler & mask)==0.
  - mask is 0, 1, 3 or 7 for `level` 0..3.
  - A change of `level` takes effect on the next tick, with no prescaler reset.
- On a step, every floor updates independently:
  - If `wy[i]` == `SCREEN_H-1`: `wy[i]`←0, `wx[i]`←slot*`X_STEP`, where slot = LFSR[3:0] mod `X_SLOTS`. `wen[i]`←1 if `GAP_EN`=0, otherwise `wen[i]`←~(LFSR[7]&LFSR[5]) (1-in-4 gaps). `wrap_cnt` increments by 1 per wrapping floor, saturating.
  - Otherwise: `wy[i]`←`wy[i]`+1, and `wx[i]` and `wen[i]` hold.
  - If several floors wrap in the same step, floor i uses the LFSR rotated left by 3i.
- `pending` is set by any step.
- On `frame_sync` with `pending`=1, all shadows are loaded from the working registers and `pending` clears.
- If a step and `frame_sync` fall in the same cycle, the shadows take the pre-step working values and `pending` stays set.
- `frame_sync` with `pending`=0 leaves all outputs unchanged.
- `run`=0 freezes the working state and the prescaler. `frame_sync` still flushes an outstanding `pending`.
- `rst` mid-operation restores all reset values on the next edge, discarding any pending update.

## Timing
- Step at edge t: the working registers change at t+1.
- Outputs change one cycle after the first `frame_sync` sampled at or after t+1.
- Minimum latency from `tick` to visible output is 2 cycles.
- All outputs are registered with no combinational path from any input.
- `tick` and `frame_sync` are single-cycle strobes. A held strobe counts once per cycle.

## Test plan
- Reset, then `frame_sync` with no tick -> `floor_y`[1]=60, `floor_x`[0]=120, `enable`=8'hFF, `wrap_cnt`=0, outputs unchanged.
- `level`=0, `run`=1, three ticks, then `frame_sync` -> `floor_y`[0]=3 and `floor_y`[7]=423. Before the `frame_sync`, outputs still show 0 and 420.
- `level`=2, eight ticks, then `frame_sync` -> every y has advanced by exactly 2.
- Drive floor 7 from 420 to 479, then one more step -> `floor_y`[7]=0, `floor_x`[7] is a multiple of 40 and <640, `wrap_cnt`=1.
- Step and `frame_sync` in the same cycle -> shadows show pre-step values. The next `frame_sync` shows post-step values.
- `GAP_EN`=1: run 4000 steps -> `wrap_cnt` matches the reference model, roughly 25% of respawns have `enable`=0, and a `rst` pulse mid-run restores all reset values.
